// File: rtl/nvram_bank.sv
// nvram_bank: dual-port byte NVRAM with CPU bus port, HPS backup port
// and per-block dirty tracking for incremental backup.
module nvram_bank #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int BLOCK_W = 9
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_cs,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic                      cpu_uds,
  input  logic                      cpu_lds,
  input  logic                      cpu_write_strobe,
  input  logic [DATA_W-1:0]         cpu_din,
  output logic [2*DATA_W-1:0]       cpu_dout,
  output logic                      cpu_bus_ack,
  input  logic                      cpu_allow,
  output logic                      cpu_changed,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [DATA_W-1:0]         host_wdata,
  input  logic                      host_we,
  output logic [DATA_W-1:0]         host_rdata,
  output logic                      dirty_valid,
  output logic [ADDR_W-BLOCK_W-1:0] dirty_block,
  input  logic                      dirty_ack,
  input  logic                      dirty_clear_all,
  output logic [ADDR_W-BLOCK_W:0]   dirty_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BW    = ADDR_W - BLOCK_W;
  localparam int NBLK  = 1 << BW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q;
  logic              wr_acc;
  logic              wr_path_ack;
  logic              rd_req;
  logic              rd_ack_q;
  logic [BW-1:0]     cpu_blk;
  logic [NBLK-1:0]   bitmap;
  logic [NBLK-1:0]   bitmap_nx;
  logic [BW-1:0]     low_idx;
  logic [BW:0]       pop;

  // Only the upper lane is backed; lds-only writes are acked but dropped.
  assign wr_acc      = cpu_cs & cpu_uds & cpu_write_strobe & cpu_allow;
  assign wr_path_ack = cpu_cs & cpu_write_strobe
                     & (cpu_uds | cpu_lds) & cpu_allow;
  assign rd_req      = cpu_cs & ~cpu_write_strobe
                     & (cpu_uds | cpu_lds) & cpu_allow;
  assign cpu_bus_ack = wr_path_ack | rd_ack_q;
  assign cpu_dout    = {q, q};
  assign cpu_blk     = cpu_addr[ADDR_W-1:BLOCK_W];

  // Storage: both ports read-before-write; host write lands last so it
  // wins a same-address collision.
  always_ff @(posedge clk) begin
    q          <= mem[cpu_addr];
    host_rdata <= mem[host_addr];
    if (wr_acc)
      mem[cpu_addr] <= cpu_din;
    if (host_we)
      mem[host_addr] <= host_wdata;
  end

  // Next bitmap: clears first, a CPU write set overrides them.
  always_comb begin
    bitmap_nx = bitmap;
    if (dirty_clear_all)
      bitmap_nx = '0;
    if (dirty_ack && dirty_valid)
      bitmap_nx[dirty_block] = 1'b0;
    if (wr_acc)
      bitmap_nx[cpu_blk] = 1'b1;
  end

  // Lowest dirty index and population count of the current bitmap.
  always_comb begin
    low_idx = '0;
    pop     = '0;
    for (int i = NBLK - 1; i >= 0; i--) begin
      if (bitmap[i])
        low_idx = BW'(i);
      pop = pop + {{BW{1'b0}}, bitmap[i]};
    end
  end

  // Control state: read ack toggle, write pulse, bitmap and reports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack_q    <= 1'b0;
      cpu_changed <= 1'b0;
      bitmap      <= '0;
      dirty_valid <= 1'b0;
      dirty_block <= '0;
      dirty_count <= '0;
    end else begin
      rd_ack_q    <= rd_req & ~rd_ack_q;
      cpu_changed <= wr_acc;
      bitmap      <= bitmap_nx;
      dirty_valid <= |bitmap;
      dirty_block <= low_idx;
      dirty_count <= pop;
    end
  end

endmodule
